// File: rtl/cordic_rot_issuer.sv
// cordic_rot_issuer: quadrant-folding front-end for the iterative CORDIC
// rotation core; one request in flight, result returned with its phase.
module cordic_rot_issuer #(
  parameter int          ANGLE_FRAC = 13,
  parameter logic [15:0] K_RAD      = 16'hC910,
  parameter int          TIMEOUT    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_phase,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        core_start,
  output logic [15:0] core_angle,
  output logic [15:0] core_v0,
  output logic [15:0] core_v1,
  input  logic        core_ready,
  input  logic [15:0] core_v0_res,
  input  logic [15:0] core_v1_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic [15:0] out_phase,
  output logic        err_timeout
);

  localparam int          CW     = $clog2(TIMEOUT) + 1;
  localparam logic [15:0] HALF_Q = 16'(1 << ANGLE_FRAC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t         r_state;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_err;
  logic           r_skip;
  logic [CW-1:0]  r_cnt;
  logic [15:0]    r_phase;
  logic [15:0]    r_angle;
  logic [15:0]    r_v0;
  logic [15:0]    r_v1;
  logic [15:0]    r_x;
  logic [15:0]    r_y;

  logic [15:0]        w_sum;
  logic [1:0]         w_q;
  logic signed [15:0] w_r;
  logic signed [31:0] w_prod;
  logic [15:0]        w_ang;
  logic [15:0]        w_nx;
  logic [15:0]        w_ny;
  logic [15:0]        w_v0;
  logic [15:0]        w_v1;

  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    return ~v + 16'd1;
  endfunction

  // Round the phase to the nearest quadrant; the remainder is the
  // residual the core still has to rotate through.
  assign w_sum  = in_phase + HALF_Q;
  assign w_q    = 2'(w_sum >> 14);
  assign w_r    = $signed(in_phase - {w_q, 14'd0});
  assign w_prod = $signed({{16{w_r[15]}}, w_r})
                * $signed({16'd0, K_RAD});
  assign w_ang  = 16'(w_prod >>> 16);

  assign w_nx = neg_sat(in_x);
  assign w_ny = neg_sat(in_y);

  always_comb begin
    w_v0 = in_x;
    w_v1 = in_y;
    unique case (w_q)
      2'd0: begin
        w_v0 = in_x;
        w_v1 = in_y;
      end
      2'd1: begin
        w_v0 = w_ny;
        w_v1 = in_x;
      end
      2'd2: begin
        w_v0 = w_nx;
        w_v1 = w_ny;
      end
      2'd3: begin
        w_v0 = in_y;
        w_v1 = w_nx;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_skip      <= 1'b0;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_angle     <= '0;
      r_v0        <= '0;
      r_v1        <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= S_ISSUE;
            r_in_ready <= 1'b0;
            r_phase    <= in_phase;
            r_angle    <= w_ang;
            r_v0       <= w_v0;
            r_v1       <= w_v1;
          end
        end
        S_ISSUE: begin
          if (core_ready) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_skip  <= 1'b1;
          end
        end
        S_WAIT: begin
          // Core ready is still stale on the edge right after start.
          r_skip <= 1'b0;
          if (!r_skip && core_ready) begin
            r_x         <= core_v0_res;
            r_y         <= core_v1_res;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign core_start  = (r_state == S_ISSUE) && core_ready;
  assign core_angle  = r_angle;
  assign core_v0     = r_v0;
  assign core_v1     = r_v1;
  assign out_valid   = r_out_valid;
  assign out_x       = r_x;
  assign out_y       = r_y;
  assign out_phase   = r_phase;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_cordic_rot_issuer.sv
// tb_cordic_rot_issuer: directed vectors, behavioural core model and
// queue-based scoreboards for the core request and the output result.
module tb_cordic_rot_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_phase;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        core_start;
  logic [15:0] core_angle;
  logic [15:0] core_v0;
  logic [15:0] core_v1;
  logic        core_ready;
  logic [15:0] core_v0_res;
  logic [15:0] core_v1_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [15:0] out_phase;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } trip_t;

  trip_t cq[$];
  trip_t oq[$];

  int   core_busy = 0;
  int   core_n = 10;
  logic core_force_low = 1'b0;
  logic core_abort = 1'b0;

  cordic_rot_issuer dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_phase(in_phase),
    .in_x(in_x),
    .in_y(in_y),
    .core_start(core_start),
    .core_angle(core_angle),
    .core_v0(core_v0),
    .core_v1(core_v1),
    .core_ready(core_ready),
    .core_v0_res(core_v0_res),
    .core_v1_res(core_v1_res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x(out_x),
    .out_y(out_y),
    .out_phase(out_phase),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: busy for core_n cycles, returns (v0+3, v1+5).
  assign core_ready = (core_busy == 0) && !core_force_low;

  always @(posedge clk) begin
    if (reset || core_abort) begin
      core_busy <= 0;
    end else if (core_start) begin
      core_busy   <= core_n;
      core_v0_res <= core_v0 + 16'd3;
      core_v1_res <= core_v1 + 16'd5;
    end else if (core_busy > 0) begin
      core_busy <= core_busy - 1;
    end
  end

  initial begin
    core_v0_res = '0;
    core_v1_res = '0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=expired expected=event", name);
  endtask

  always @(negedge clk) begin
    if (!reset && core_start) begin
      trip_t e;
      chk("start_with_ready", 32'(core_ready), 32'd1);
      if (cq.size() == 0) begin
        bad("unexpected_core_start");
      end else begin
        e = cq.pop_front();
        chk("core_v0", 32'(core_v0), 32'(e.a));
        chk("core_v1", 32'(core_v1), 32'(e.b));
        chk("core_angle", 32'(core_angle), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      trip_t e;
      if (oq.size() == 0) begin
        bad("unexpected_out_valid");
      end else begin
        e = oq.pop_front();
        chk("out_x", 32'(out_x), 32'(e.a));
        chk("out_y", 32'(out_y), 32'(e.b));
        chk("out_phase", 32'(out_phase), 32'(e.c));
      end
    end
  end

  typedef struct {
    logic [15:0] ph, x, y, v0, v1, ang, ox, oy;
  } vec_t;

  int t_acc;

  // Called at a negedge; returns just after the accepting edge.
  task automatic send(input vec_t v, input bit push_out);
    bit acc = 0;
    in_valid = 1'b1;
    in_phase = v.ph;
    in_x     = v.x;
    in_y     = v.y;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        cq.push_back('{v.v0, v.v1, v.ang});
        if (push_out) oq.push_back('{v.ox, v.oy, v.ph});
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    t_acc = cyc;
    if (!acc) bad("accept");
  endtask

  task automatic wait_ov();
    bit seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) bad("wait_out_valid");
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (oq.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) bad("drain");
  endtask

  vec_t tv[6];
  vec_t va, vb, vt, vr, vf;
  int   t_s;

  initial begin
    tv[0] = '{16'h4000, 16'h0080, 16'h0000, 16'h0000, 16'h0080,
              16'h0000, 16'h0003, 16'h0085};
    tv[1] = '{16'h2000, 16'h0100, 16'h0040, 16'hFFC0, 16'h0100,
              16'hE6DE, 16'hFFC3, 16'h0105};
    tv[2] = '{16'h1FFF, 16'h0100, 16'h0040, 16'h0100, 16'h0040,
              16'h1921, 16'h0103, 16'h0045};
    tv[3] = '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000,
              16'h0000, 16'h8002, 16'h0005};
    tv[4] = '{16'hFFFF, 16'h0020, 16'h8000, 16'h0020, 16'h8000,
              16'hFFFF, 16'h0023, 16'h8005};
    tv[5] = '{16'hC000, 16'h8000, 16'h0011, 16'h0011, 16'h7FFF,
              16'h0000, 16'h0014, 16'h8004};
    va = '{16'h6000, 16'h0123, 16'hFF00, 16'hFEDD, 16'h0100,
           16'hE6DE, 16'hFEE0, 16'h0105};
    vb = '{16'h3000, 16'h0040, 16'h0020, 16'hFFE0, 16'h0040,
           16'hF36F, 16'hFFE3, 16'h0045};
    vt = '{16'h0000, 16'h0001, 16'h0002, 16'h0001, 16'h0002,
           16'h0000, 16'h0000, 16'h0000};
    vr = '{16'h0100, 16'h0005, 16'h0006, 16'h0005, 16'h0006,
           16'h00C9, 16'h0000, 16'h0000};
    vf = '{16'h1000, 16'h0007, 16'h0008, 16'h0007, 16'h0008,
           16'h0C91, 16'h000A, 16'h000D};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_phase  = '0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    chk("rst_core_v0", 32'(core_v0), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tv[i]) begin
      send(tv[i], 1'b1);
      wait_ov();
      chk("latency", 32'(cyc - t_acc), 32'd12);
      drain();
    end

    // Consumer back-pressure with a second request waiting.
    out_ready = 1'b0;
    send(va, 1'b1);
    wait_ov();
    in_valid = 1'b1;
    in_phase = vb.ph;
    in_x     = vb.x;
    in_y     = vb.y;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_x", 32'(out_x), 32'(va.ox));
      chk("hold_out_y", 32'(out_y), 32'(va.oy));
      chk("hold_out_phase", 32'(out_phase), 32'(va.ph));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send(vb, 1'b1);
    out_ready = 1'b1;
    drain();

    // Issue stall, then a core that never finishes.
    core_force_low = 1'b1;
    core_n = 1000;
    send(vt, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_start", 32'(core_start), 32'd0);
    end
    @(posedge clk);
    #1;
    core_force_low = 1'b0;
    t_s = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err_timeout) break;
    end
    chk("timeout_cycle", 32'(cyc - t_s), 32'd33);
    chk("timeout_err", 32'(err_timeout), 32'd1);
    chk("timeout_in_ready", 32'(in_ready), 32'd1);
    chk("timeout_out_valid", 32'(out_valid), 32'd0);
    core_abort = 1'b1;
    @(negedge clk);
    core_abort = 1'b0;
    core_n = 10;
    chk("cq_empty_timeout", 32'(cq.size()), 32'd0);

    // Reset while the core is busy; in_valid during reset is ignored.
    send(vr, 1'b0);
    repeat (6) @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_phase = 16'h1234;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rstw_out_valid", 32'(out_valid), 32'd0);
    chk("rstw_in_ready", 32'(in_ready), 32'd1);
    chk("rstw_err", 32'(err_timeout), 32'd0);
    repeat (25) @(negedge clk);
    chk("rstw_idle", 32'(in_ready), 32'd1);

    send(vf, 1'b1);
    wait_ov();
    chk("latency_final", 32'(cyc - t_acc), 32'd12);
    drain();
    chk("oq_empty", 32'(oq.size()), 32'd0);
    chk("cq_empty", 32'(cq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

endmodule
